// File: rtl/add_step_pkg.sv
// Shared types for the key-driven adder sequencer.
package add_step_pkg;

  // Sequencer states; the value is the code shown (inverted) on state_n.
  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    SHOW   = 2'b10
  } state_e;

  // Interpretation of the operands when the sum is displayed.
  typedef enum logic {
    UNSIGNED = 1'b0,
    SIGNED   = 1'b1
  } mode_e;

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces one active-low key; emits a level and a
// single-cycle pulse on each accepted press.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pressed,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pressed_q, pressed_d;
  logic          press_q, press_d;
  logic          raw_pressed;

  assign raw_pressed = ~sync_q[1];

  // Two-flop synchronizer; resets to the released level so no press is
  // seen coming out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], key_n};
  end

  // Count consecutive cycles where the raw level disagrees with the accepted
  // one; accept on the last of them. Any agreeing cycle restarts the count.
  always_comb begin
    cnt_d     = '0;
    pressed_d = pressed_q;
    press_d   = 1'b0;
    if (raw_pressed != pressed_q) begin
      if (cnt_q == LAST) begin
        pressed_d = raw_pressed;
        press_d   = raw_pressed;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
    end
  end

  assign pressed = pressed_q;
  assign press   = press_q;

endmodule

// File: rtl/add_step_controller.sv
// Step key captures A then B from the switches, then shows A+B with a
// carry (unsigned) or overflow (signed) flag; mode key toggles the view.
module add_step_controller
  import add_step_pkg::*;
#(
  parameter int W               = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   key_n,
  input  logic [W-1:0] sw_n,
  output logic [W+1:0] led_n,
  output logic [1:0]   state_n,
  output logic         vcc_for_keys
);

  logic         step_press, mode_press;
  logic [W-1:0] sw_s1_q, sw_s2_q, a;
  state_e       state_q, state_d;
  mode_e        mode_q, mode_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [W+1:0] led_q, led_d;
  logic [1:0]   state_n_q, state_n_d;
  logic [W:0]   sum;
  logic         flag;

  assign vcc_for_keys = 1'b1;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clk(clk), .rst_n(rst_n), .key_n(key_n[0]), .pressed(), .press(step_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk(clk), .rst_n(rst_n), .key_n(key_n[1]), .pressed(), .press(mode_press)
  );

  // Switch synchronizer; idles at "all off" so the live value starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_q <= '1;
      sw_s2_q <= '1;
    end else begin
      sw_s1_q <= sw_n;
      sw_s2_q <= sw_s1_q;
    end
  end

  assign a = ~sw_s2_q;

  // Exact W+1 bit sum; flag is carry-out or two's-complement overflow.
  always_comb begin
    if (mode_q == SIGNED) begin
      sum  = {a_q[W-1], a_q} + {b_q[W-1], b_q};
      flag = (a_q[W-1] == b_q[W-1]) && (sum[W-1] != a_q[W-1]);
    end else begin
      sum  = {1'b0, a_q} + {1'b0, b_q};
      flag = sum[W];
    end
  end

  // Next-state: step always wins over a same-cycle mode press.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      LOAD_A: if (step_press) begin a_d = a; state_d = LOAD_B; end
      LOAD_B: if (step_press) begin b_d = a; state_d = SHOW;   end
      SHOW: begin
        if (step_press)      state_d = LOAD_A;
        else if (mode_press) mode_d  = (mode_q == SIGNED) ? UNSIGNED : SIGNED;
      end
      default: state_d = LOAD_A;
    endcase
  end

  // Output decode from the registered state, one cycle behind it.
  always_comb begin
    state_n_d = ~state_q;
    if (state_q == SHOW) led_d = ~{flag, sum};
    else                 led_d = {2'b11, ~a};
  end

  // State, operand, mode and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD_A;
      mode_q    <= UNSIGNED;
      a_q       <= '0;
      b_q       <= '0;
      led_q     <= '1;
      state_n_q <= 2'b11;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      a_q       <= a_d;
      b_q       <= b_d;
      led_q     <= led_d;
      state_n_q <= state_n_d;
    end
  end

  assign led_n   = led_q;
  assign state_n = state_n_q;

endmodule

// File: tb/tb_add_step_controller.sv
// Directed bench for add_step_controller with a queue-based scoreboard.
module tb_add_step_controller;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   key_n;
  logic [W-1:0] sw_n;
  logic [W+1:0] led_n;
  logic [1:0]   state_n;
  logic         vcc_for_keys;

  typedef struct packed {
    logic [W+1:0] led;
    logic [1:0]   st;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;

  add_step_controller #(.W(W), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n), .sw_n(sw_n),
    .led_n(led_n), .state_n(state_n), .vcc_for_keys(vcc_for_keys)
  );

  always #5 clk = ~clk;

  // Monitor: compares outputs against whatever the stimulus queued.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (led_n !== e.led || state_n !== e.st || vcc_for_keys !== 1'b1) begin
        failures++;
        $display("FAIL %s: got led_n=%b state_n=%b vcc=%b, want led_n=%b state_n=%b vcc=1",
                 n, led_n, state_n, vcc_for_keys, e.led, e.st);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue an expectation to be checked at the next falling edge.
  task automatic expect_out(input string n, input logic [W+1:0] led, input logic [1:0] st);
    exp_t e;
    e.led = led;
    e.st  = st;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(negedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] mask);
    key_n = ~mask;
    cyc(8);
    key_n = 2'b11;
    cyc(10);
  endtask

  initial begin
    rst_n = 1'b0;
    key_n = 2'b11;
    sw_n  = 2'b11;
    cyc(3);
    expect_out("in_reset", 4'b1111, 2'b11);
    rst_n = 1'b1;
    cyc(10);
    expect_out("idle_after_reset", 4'b1111, 2'b11);

    // Short glitch is rejected, longer press steps once.
    key_n = 2'b10; cyc(3); key_n = 2'b11; cyc(12);
    expect_out("glitch_ignored", 4'b1111, 2'b11);
    key_n = 2'b10; cyc(6); key_n = 2'b11; cyc(12);
    expect_out("one_step_load_b", 4'b1111, 2'b10);
    press(2'b01);
    expect_out("show_zero", 4'b1111, 2'b01);

    // Asynchronous reset mid-SHOW takes effect without a clock edge.
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    if (led_n !== 4'b1111 || state_n !== 2'b11) begin
      failures++;
      $display("FAIL async_reset: got led_n=%b state_n=%b, want 1111 11", led_n, state_n);
    end
    checks++;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    expect_out("after_mid_reset", 4'b1111, 2'b11);

    // Live switch latency: 3 edges from pin to LED.
    sw_n = 2'b00;
    cyc(2);
    expect_out("sw_not_yet", 4'b1111, 2'b11);
    cyc(1);
    expect_out("sw_live", 4'b1100, 2'b11);

    // Unsigned 3 + 1 = 4, carry.
    press(2'b01);
    sw_n = 2'b10;
    press(2'b01);
    expect_out("unsigned_3p1", 4'b0011, 2'b01);
    press(2'b10);
    expect_out("signed_m1p1", 4'b1111, 2'b01);
    press(2'b10);
    expect_out("back_unsigned", 4'b0011, 2'b01);
    press(2'b10);

    // Signed 1 + 1 overflows.
    press(2'b01);
    expect_out("load_a_live", 4'b1110, 2'b11);
    press(2'b01);
    press(2'b01);
    expect_out("signed_1p1", 4'b0101, 2'b01);

    // Signed -2 + -2 overflows.
    press(2'b01);
    sw_n = 2'b01;
    press(2'b01);
    press(2'b01);
    expect_out("signed_m2m2", 4'b0011, 2'b01);

    // Step and mode together: step wins, mode stays signed.
    press(2'b11);
    expect_out("both_to_load_a", 4'b1101, 2'b11);
    sw_n = 2'b10;
    press(2'b01);
    press(2'b01);
    expect_out("mode_kept_signed", 4'b0101, 2'b01);

    // Mode press in LOAD_A is ignored.
    press(2'b01);
    press(2'b10);
    expect_out("mode_ignored_state", 4'b1110, 2'b11);
    press(2'b01);
    press(2'b01);
    expect_out("mode_ignored_sum", 4'b0101, 2'b01);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
